// File: rtl/sfx_scheduler_if.sv
// Audio sample RAM read port shared between the scheduler and the RAM.
//   ram_addr : registered read address driven by the scheduler
//   ram_data : read data returned by the RAM one clock after ram_addr changes
// master = scheduler side, slave = RAM side.
interface sfx_scheduler_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  modport master (output ram_addr, input ram_data);
  modport slave  (input ram_addr, output ram_data);
endinterface

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates the shared audio sample RAM between
// NUM_SFX requesters and fetches one sample per codec frame (LRCLK rise).
// Ports:
//   Clk, Reset      : system clock, synchronous active-high reset
//   lrclk           : codec LRCLK (asynchronous, synchronized here)
//   req             : per-effect trigger, rising edge latches a pending bit
//   cfg_start/len   : per-effect start address and length, slice i = effect i
//   enable          : 0 mutes output and parks the sequencer in IDLE
//   ram             : RAM read port (ram_addr out, ram_data in)
//   sample_out      : registered sample to the codec
//   busy, active_id : playing flag and index of the playing effect
//   done, done_id   : one-clock pulse and index when an effect ends
// NUM_SFX must be at least 2 so that the id fields are non-empty.
module sfx_scheduler #(
  parameter int NUM_SFX = 4,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 16,
  localparam int ID_W   = $clog2(NUM_SFX)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      lrclk,
  input  logic [NUM_SFX-1:0]        req,
  input  logic [NUM_SFX*ADDR_W-1:0] cfg_start,
  input  logic [NUM_SFX*ADDR_W-1:0] cfg_len,
  input  logic                      enable,
  sfx_scheduler_if.master           ram,
  output logic [DATA_W-1:0]         sample_out,
  output logic                      busy,
  output logic [ID_W-1:0]           active_id,
  output logic                      done,
  output logic [ID_W-1:0]           done_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_ADDR,
    S_WAIT,
    S_LATCH
  } state_t;

  state_t state, state_next;

  logic lrclk_s1, lrclk_s2, lrclk_d;
  logic tick;
  logic [NUM_SFX-1:0] req_d, req_rise, pending, grant_mask;
  logic [ADDR_W-1:0] ptr, remaining;

  logic win_found;
  logic [ID_W-1:0] win_id;
  logic [ADDR_W-1:0] sel_start, sel_len;
  logic grant, grant_play;

  assign tick     = lrclk_s2 & ~lrclk_d;
  assign req_rise = req & ~req_d;

  // Lowest-index pending bit wins; scanning downwards lets the lowest index
  // overwrite any higher one found earlier.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NUM_SFX - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end

  assign sel_start = cfg_start[win_id*ADDR_W +: ADDR_W];
  assign sel_len   = cfg_len[win_id*ADDR_W +: ADDR_W];

  // Arbitration happens only on a frame tick while the sequencer is between
  // fetches. The winner takes over when idle, when it outranks the playing
  // effect, or when it is the playing effect itself (restart).
  // A zero-length grant only consumes the pending bit and leaves playback alone.
  assign grant = tick && enable && win_found &&
                 (state == S_IDLE || state == S_PLAY) &&
                 (!busy || win_id <= active_id);
  assign grant_play = grant && (sel_len != '0);
  assign grant_mask = grant ? (NUM_SFX'(1) << win_id) : '0;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: one ADDR/WAIT/LATCH pass per frame, then back to PLAY
  // to wait for the next tick, or to IDLE after the last sample.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (grant_play) state_next = S_ADDR;
      S_PLAY:  if (tick) state_next = S_ADDR;
      S_ADDR:  state_next = S_WAIT;
      S_WAIT:  state_next = S_LATCH;
      S_LATCH: state_next = (remaining == '0) ? S_IDLE : S_PLAY;
      default: state_next = S_IDLE;
    endcase
    if (!enable) state_next = S_IDLE;
  end

  // Datapath and registered outputs. Pending bits keep latching even while
  // muted; a request edge in the same cycle as its grant wins over the clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lrclk_s1     <= 1'b0;
      lrclk_s2     <= 1'b0;
      lrclk_d      <= 1'b0;
      req_d        <= '0;
      pending      <= '0;
      ptr          <= '0;
      remaining    <= '0;
      ram.ram_addr <= '0;
      sample_out   <= '0;
      busy         <= 1'b0;
      active_id    <= '0;
      done         <= 1'b0;
      done_id      <= '0;
    end else begin
      lrclk_s1 <= lrclk;
      lrclk_s2 <= lrclk_s1;
      lrclk_d  <= lrclk_s2;
      req_d    <= req;
      pending  <= (pending & ~grant_mask) | req_rise;
      done     <= 1'b0;

      if (!enable) begin
        busy       <= 1'b0;
        active_id  <= '0;
        sample_out <= '0;
      end else begin
        if (grant_play) begin
          ptr       <= sel_start;
          remaining <= sel_len;
          busy      <= 1'b1;
          active_id <= win_id;
        end

        if (tick && state == S_IDLE) sample_out <= '0;

        case (state)
          S_ADDR: begin
            ram.ram_addr <= ptr;
            ptr          <= ptr + ADDR_W'(1);
            remaining    <= remaining - ADDR_W'(1);
          end
          S_LATCH: begin
            sample_out <= ram.ram_data;
            if (remaining == '0) begin
              done      <= 1'b1;
              done_id   <= active_id;
              busy      <= 1'b0;
              active_id <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Testbench for sfx_scheduler. Each frame task raises lrclk; a scoreboard
// monitor pops the expected frame outcome and compares the DUT outputs at
// fixed offsets from the lrclk rise (tick is seen after two sync stages).
module tb_sfx_scheduler;
  localparam int NUM_SFX = 4;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sample;
    logic              busy_e;
    logic [1:0]        id_e;
    logic              busy_l;
    logic [1:0]        id_l;
    logic              done;
    logic [1:0]        done_id;
  } frame_exp_t;

  logic Clk = 1'b0;
  logic Reset, lrclk, enable;
  logic [NUM_SFX-1:0] req;
  logic [NUM_SFX*ADDR_W-1:0] cfg_start, cfg_len;
  logic [DATA_W-1:0] sample_out;
  logic busy, done;
  logic [1:0] active_id, done_id;

  int checks = 0;
  int errors = 0;
  frame_exp_t exp_q[$];

  sfx_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  sfx_scheduler #(.NUM_SFX(NUM_SFX), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Reset(Reset), .lrclk(lrclk), .req(req),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .enable(enable),
    .ram(bus.master), .sample_out(sample_out), .busy(busy),
    .active_id(active_id), .done(done), .done_id(done_id)
  );

  always #10 Clk = ~Clk;

  // Synchronous RAM whose content equals its address.
  always_ff @(posedge Clk) bus.ram_data <= DATA_W'(bus.ram_addr);

  task automatic set_cfg(input int i, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] l);
    cfg_start[i*ADDR_W +: ADDR_W] = s;
    cfg_len[i*ADDR_W +: ADDR_W]   = l;
  endtask

  task automatic push(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] sample,
                      input logic busy_e, input logic [1:0] id_e,
                      input logic busy_l, input logic [1:0] id_l,
                      input logic dn, input logic [1:0] dn_id);
    frame_exp_t e;
    e.addr = addr; e.sample = sample; e.busy_e = busy_e; e.id_e = id_e;
    e.busy_l = busy_l; e.id_l = id_l; e.done = dn; e.done_id = dn_id;
    exp_q.push_back(e);
  endtask

  task automatic pulse_req(input int i);
    @(negedge Clk); req[i] = 1'b1;
    @(negedge Clk); req[i] = 1'b0;
    @(negedge Clk);
  endtask

  task automatic frame();
    lrclk = 1'b1;
    repeat (6) @(negedge Clk);
    lrclk = 1'b0;
    repeat (8) @(negedge Clk);
  endtask

  // Scoreboard monitor: one expected entry per lrclk rise.
  task automatic monitor();
    frame_exp_t e;
    int dn_cnt;
    forever begin
      @(posedge lrclk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL frame_expect: got frame with empty scoreboard, required an entry");
        continue;
      end
      e = exp_q.pop_front();
      dn_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
        @(negedge Clk);
        if (done) dn_cnt++;
        if (k == 3) begin
          checks += 2;
          if (busy !== e.busy_e) begin
            errors++; $display("[TB] FAIL busy_tick: got %b required %b", busy, e.busy_e);
          end
          if (active_id !== e.id_e) begin
            errors++; $display("[TB] FAIL active_id_tick: got %0d required %0d", active_id, e.id_e);
          end
        end
        if (k == 4) begin
          checks++;
          if (bus.ram_addr !== e.addr) begin
            errors++; $display("[TB] FAIL ram_addr: got %h required %h", bus.ram_addr, e.addr);
          end
        end
        if (k == 6) begin
          checks++;
          if (sample_out !== e.sample) begin
            errors++; $display("[TB] FAIL sample_out: got %h required %h", sample_out, e.sample);
          end
          if (e.done) begin
            checks++;
            if (done !== 1'b1 || done_id !== e.done_id) begin
              errors++; $display("[TB] FAIL done_pulse: got done=%b id=%0d required done=1 id=%0d",
                                 done, done_id, e.done_id);
            end
          end
        end
        if (k == 7) begin
          checks += 2;
          if (busy !== e.busy_l) begin
            errors++; $display("[TB] FAIL busy_late: got %b required %b", busy, e.busy_l);
          end
          if (active_id !== e.id_l) begin
            errors++; $display("[TB] FAIL active_id_late: got %0d required %0d", active_id, e.id_l);
          end
        end
      end
      checks++;
      if (dn_cnt != (e.done ? 1 : 0)) begin
        errors++; $display("[TB] FAIL done_count: got %0d required %0d", dn_cnt, e.done ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; lrclk = 1'b0; enable = 1'b1; req = '0;
    cfg_start = '0; cfg_len = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if ({bus.ram_addr, sample_out, busy, active_id, done, done_id} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got addr=%h smp=%h busy=%b id=%0d done=%b did=%0d required all 0",
               bus.ram_addr, sample_out, busy, active_id, done, done_id);
    end
  endtask

  task automatic test_basic();
    set_cfg(1, 14'h0100, 14'd3);
    pulse_req(1);
    push(14'h0100, 16'h0100, 1, 1, 1, 1, 0, 0);
    push(14'h0101, 16'h0101, 1, 1, 1, 1, 0, 0);
    push(14'h0102, 16'h0102, 1, 1, 0, 0, 1, 1);
    push(14'h0102, 16'h0000, 0, 0, 0, 0, 0, 0);
    push(14'h0102, 16'h0000, 0, 0, 0, 0, 0, 0);
    repeat (5) frame();
  endtask

  task automatic test_preempt();
    set_cfg(2, 14'h0400, 14'd10);
    set_cfg(0, 14'h0200, 14'd2);
    pulse_req(2);
    for (int i = 0; i < 4; i++) push(14'h0400 + 14'(i), 16'h0400 + 16'(i), 1, 2, 1, 2, 0, 0);
    repeat (4) frame();
    pulse_req(0);
    push(14'h0200, 16'h0200, 1, 0, 1, 0, 0, 0);
    push(14'h0201, 16'h0201, 1, 0, 0, 0, 1, 0);
    push(14'h0201, 16'h0000, 0, 0, 0, 0, 0, 0);
    repeat (3) frame();
  endtask

  task automatic test_priority();
    set_cfg(3, 14'h0800, 14'd1);
    pulse_req(0);
    push(14'h0200, 16'h0200, 1, 0, 1, 0, 0, 0);
    frame();
    pulse_req(3);
    push(14'h0201, 16'h0201, 1, 0, 0, 0, 1, 0);
    push(14'h0800, 16'h0800, 1, 3, 0, 0, 1, 3);
    push(14'h0800, 16'h0000, 0, 0, 0, 0, 0, 0);
    repeat (3) frame();
  endtask

  task automatic test_wrap();
    set_cfg(0, 14'h3FFE, 14'd4);
    pulse_req(0);
    push(14'h3FFE, 16'h3FFE, 1, 0, 1, 0, 0, 0);
    push(14'h3FFF, 16'h3FFF, 1, 0, 1, 0, 0, 0);
    push(14'h0000, 16'h0000, 1, 0, 1, 0, 0, 0);
    push(14'h0001, 16'h0001, 1, 0, 0, 0, 1, 0);
    repeat (4) frame();
  endtask

  task automatic test_zero_len();
    set_cfg(2, 14'h0400, 14'd0);
    pulse_req(2);
    push(14'h0001, 16'h0000, 0, 0, 0, 0, 0, 0);
    frame();
    // A non-zero length now must not play: the pending bit was consumed.
    set_cfg(2, 14'h0400, 14'd5);
    push(14'h0001, 16'h0000, 0, 0, 0, 0, 0, 0);
    frame();
  endtask

  task automatic test_back_to_back();
    pulse_req(1);
    push(14'h0100, 16'h0100, 1, 1, 1, 1, 0, 0);
    frame();
    pulse_req(1);
    push(14'h0100, 16'h0100, 1, 1, 1, 1, 0, 0);
    push(14'h0101, 16'h0101, 1, 1, 1, 1, 0, 0);
    push(14'h0102, 16'h0102, 1, 1, 0, 0, 1, 1);
    push(14'h0102, 16'h0000, 0, 0, 0, 0, 0, 0);
    repeat (4) frame();
  endtask

  task automatic test_enable();
    set_cfg(0, 14'h0200, 14'd2);
    pulse_req(1);
    push(14'h0100, 16'h0100, 1, 1, 1, 1, 0, 0);
    frame();
    enable = 1'b0;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || sample_out !== '0 || active_id !== '0) begin
      errors++;
      $display("[TB] FAIL mute_outputs: got busy=%b smp=%h id=%0d required 0/0/0",
               busy, sample_out, active_id);
    end
    pulse_req(0);
    push(14'h0100, 16'h0000, 0, 0, 0, 0, 0, 0);
    frame();
    enable = 1'b1;
    push(14'h0200, 16'h0200, 1, 0, 1, 0, 0, 0);
    push(14'h0201, 16'h0201, 1, 0, 0, 0, 1, 0);
    push(14'h0201, 16'h0000, 0, 0, 0, 0, 0, 0);
    repeat (3) frame();
  endtask

  task automatic test_reset_mid();
    pulse_req(2);
    push(14'h0400, 16'h0400, 1, 2, 1, 2, 0, 0);
    frame();
    pulse_req(3);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++;
    if ({bus.ram_addr, sample_out, busy, active_id, done, done_id} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got addr=%h smp=%h busy=%b id=%0d done=%b did=%0d required all 0",
               bus.ram_addr, sample_out, busy, active_id, done, done_id);
    end
    push(14'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    frame();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_preempt();
    test_priority();
    test_wrap();
    test_zero_len();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    repeat (2) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfx_scheduler.md
Name: sfx_scheduler

Overview:
- Sequences the shared audio sample RAM feeding the codec serializer, and arbitrates it between NUM_SFX sound-effect requesters (game events and key presses).
- Once per codec frame (LRCLK rising edge), it issues one RAM read for the active effect and registers the returned word as the codec sample.
- It replaces the free-running address counter and the key-derived count enable.

Parameters:
- NUM_SFX, 4, number of requesters; index 0 has the highest priority.
- ADDR_W, 14, audio RAM address width.
- DATA_W, 16, sample width.

Ports:
- Clk  input  1  system clock (50 MHz).
- Reset  input  1  synchronous, active-high reset.
- lrclk  input  1  codec LRCLK, asynchronous to Clk; synchronized internally.
- req  input  NUM_SFX  per-effect trigger. Level is sampled each Clk; a rising edge sets that effect's pending bit.
- cfg_start  input  NUM_SFX*ADDR_W  start address per effect; slice i is effect i.
- cfg_len  input  NUM_SFX*ADDR_W  length in samples per effect.
- enable  input  1  0 = mute: no reads are issued, sample_out is held at 0, requests still latch.
- ram_addr  output  ADDR_W  registered read address to the audio RAM.
- ram_data  input  DATA_W  RAM read data, valid 1 Clk after ram_addr changes.
- sample_out  output  DATA_W  registered sample to the codec.
- busy  output  1  high while an effect is playing.
- active_id  output  $clog2(NUM_SFX)  index of the playing effect; 0 when idle.
- done  output  1  one-Clk pulse when an effect plays its last sample.
- done_id  output  $clog2(NUM_SFX)  index of the finished effect, valid with done.

Behaviour:
- Reset values: every output 0; pending bits 0; state IDLE; synchronizer flops 0.
- lrclk path: 2-FF synchronizer, then an edge register. tick is a 1-Clk strobe on the synchronized rising edge.
- Pending bits: req rising edge sets pending[i]. Granting effect i clears pending[i]. A set and a grant of the same bit in the same cycle leaves it set.
- Arbitration is evaluated only in the tick cycle. The winner is the lowest-index pending bit.
  - Grant when idle.
  - Grant when the winner's index is lower than active_id (preemption).
  - Grant when the winner equals active_id (retrigger from start).
  - Lower-priority pending bits wait until the active effect ends.
- Grant with cfg_len[i]==0: pending[i] is cleared; nothing plays; no done pulse.
- States:
  - IDLE: wait for tick. If a grant occurs, load ptr=cfg_start[i], remaining=cfg_len[i], go to ADDR.
  - PLAY: on tick, if there is a preempt or retrigger grant, reload ptr/remaining and go to ADDR. Otherwise go to ADDR with the current ptr.
  - ADDR (tick+1): ram_addr<=ptr; ptr<=ptr+1 (mod 2^ADDR_W, wraps through 0); remaining<=remaining-1.
  - WAIT (tick+2): RAM latency cycle.
  - LATCH (tick+3): sample_out<=ram_data.
    - If remaining==0: pulse done with done_id=active_id, clear busy, go to IDLE.
    - Otherwise go to PLAY.
- Latency: sample_out updates at the Clk edge 3 cycles after the tick cycle; the new value is visible from tick+3 onward.
- busy/active_id: take the new values in the tick cycle of a grant and hold them until LATCH of the last sample.
- sample_out timing: it holds its value between frames. It returns to 0 on the tick after an effect ends while idle.
- Frame bound: the sequence needs 3 Clk cycles per frame. LRCLK ≥ 1 µs is guaranteed, so a tick never arrives mid-sequence. A tick seen outside IDLE/PLAY is ignored.
- enable==0: state is forced to IDLE and busy=0. Pending bits persist, and on re-enable they arbitrate at the next tick.
- Reset asserted mid-effect: everything returns to reset values on the next Clk edge.

Test Plan:
1. cfg_start[1]=0x0100, cfg_len[1]=3, RAM[a]=a; pulse req[1]; run 5 ticks -> ram_addr 0x0100, 0x0101, 0x0102; sample_out becomes 0x0100, 0x0101, 0x0102, each at tick+3; done with done_id=1 on the third LATCH; busy low afterwards; tick 4 sample_out=0.
2. Effect 2 playing (len 10) at sample 4; pulse req[0] (start 0x0200, len 2) -> at the next tick active_id=0 and ram_addr=0x0200; no done for effect 2; done_id=0 after 2 samples.
3. Effect 0 playing; pulse req[3] -> pending[3] held; after effect 0's done, the next tick grants 3 with ram_addr=cfg_start[3].
4. cfg_start[0]=0x3FFE, cfg_len[0]=4 -> ram_addr sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
5. Grant with cfg_len=0 -> busy stays 0, no ram_addr change, no done, pending bit cleared.
6. Reset high for 1 Clk mid-effect -> every output 0 next cycle, pending cleared; a subsequent tick with no req keeps busy=0.
